s7_display_mux: RTL and testbench
=================================

# s7_display_mux

Parametrised multiplexed driver for a row of common-anode 7-segment displays, successor to the basic BCD scan driver used by the stopwatch top level. Accepts DIS_NUM packed 4-bit digits plus per-digit decimal points. Adds frame-synchronous input capture, leading-zero blanking, per-digit blinking and PWM brightness control. Sits between the counter/datapath logic and the board display pins.

## Interface
- DIS_NUM, 4: number of digits, 1..8.
- MLT_CNT, 10: clock cycles each digit is selected (scan slot length), ≥2.
- BRIGHT_W, 4: brightness control width.
- BLINK_FRAMES, 8: frames per blink half-period, ≥1.
- i_clk  in  1  system clock; all logic on rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_bcd_data  in  DIS_NUM*4  packed digits; digit k = [4k+3:4k], digit 0 rightmost/least significant.
- i_dp  in  DIS_NUM  decimal point request per digit, 1 = lit.
- i_blank_lz  in  1  1 = blank leading zeros.
- i_blink  in  DIS_NUM  1 = digit blinks.
- i_bright  in  BRIGHT_W  brightness duty; 0 = dark, all-ones = full on.
- o_segments  out  7  {a,b,c,d,e,f,g}, active-low.
- o_dp  out  1  decimal point, active-low.
- o_segments_sel  out  DIS_NUM  digit select, active-low, at most one bit low.
- o_frame_start  out  1  one-cycle pulse at start of each scan frame.

## Operation
- Slot counter 0..MLT_CNT-1; on MLT_CNT-1 wraps to 0 and digit index advances 0..DIS_NUM-1, wrapping to 0.
- Frame = DIS_NUM*MLT_CNT cycles. At frame start (slot 0, digit 0) i_bcd_data, i_dp, i_blank_lz, i_blink are captured into shadow registers; mid-frame input changes are invisible until next frame (no tearing). i_bright is not shadowed.
- Glyphs (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
- Values 10..15: see Configuration.
- Leading-zero blanking (shadow i_blank_lz=1): scanning from digit DIS_NUM-1 downward, each zero digit is blanked until first nonzero digit; digit 0 never blanked. Blanked digit: segments 1111111, dp still follows i_dp.
- Blink: frame counter counts BLINK_FRAMES frames then toggles blink phase (on/off). During off phase digits with shadow i_blink bit set drive 1111111 and dp 1; select still asserted.
- Brightness: free-running BRIGHT_W-bit PWM counter. Select asserted only when pwm_cnt < i_bright, or i_bright all-ones (always). When deasserted, o_segments_sel all ones; segments still driven.

## Timing
- Reset values: o_segments 1111111, o_dp 1, o_segments_sel all ones, o_frame_start 0; slot, digit, PWM, frame counters 0; blink phase on; shadows 0.
- All outputs registered; one-cycle latency from counter state to pins.
- First edge after reset release: shadow capture, o_frame_start rises; digit 0 appears on outputs the same edge (captured data routed directly to the output register at capture edge).
- o_frame_start high exactly one cycle per frame.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous); scan restarts at digit 0.
- DIS_NUM=1: digit 0 selected continuously (subject to PWM); frame = MLT_CNT cycles.

## Configuration
- S7_HEX_EN defined: 10..15 display A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000; nonzero for leading-zero purposes.
- S7_HEX_EN undefined: 10..15 display dash 1111110 (g only); treated as nonzero.

## Test plan
- Reset then i_bcd_data=16'h1234, i_bright=all-ones: per slot sel 1110/1101/1011/0111, segments 1001100/0000110/0010010/1001111; each held 10 cycles.
- i_bcd_data=16'h0050, i_blank_lz=1: digits 3,2 blank 1111111, digit 1 shows 0100100, digit 0 shows 0000001.
- Change i_bcd_data from 16'h1111 to 16'h2222 mid-frame: remaining slots still show 1; next frame, after o_frame_start, shows 2.
- i_blink=4'b0001: digit 0 blank for 8 frames, lit 8 frames, repeating; other digits steady.
- i_bright=4: sel asserted 4 of every 16 cycles; i_bright=0: sel always 1111.
- i_bcd_data digit 0 = 4'hA: 0001000 with S7_HEX_EN, 1111110 without; assert i_rst mid-frame: all outputs at reset values same cycle.

Source files
------------

// File: rtl/s7_display_mux_if.sv
// Digit data, display controls and pin-side outputs of s7_display_mux.
// master = producer of digits and controls; slave = the display driver.
interface s7_display_mux_if #(
    parameter int DIS_NUM  = 4,
    parameter int BRIGHT_W = 4
);
    logic [DIS_NUM*4-1:0] i_bcd_data;
    logic [DIS_NUM-1:0]   i_dp;
    logic                 i_blank_lz;
    logic [DIS_NUM-1:0]   i_blink;
    logic [BRIGHT_W-1:0]  i_bright;
    logic [6:0]           o_segments;
    logic                 o_dp;
    logic [DIS_NUM-1:0]   o_segments_sel;
    logic                 o_frame_start;

    modport master (
        output i_bcd_data, i_dp, i_blank_lz, i_blink, i_bright,
        input  o_segments, o_dp, o_segments_sel, o_frame_start
    );

    modport slave (
        input  i_bcd_data, i_dp, i_blank_lz, i_blink, i_bright,
        output o_segments, o_dp, o_segments_sel, o_frame_start
    );
endinterface

// File: rtl/s7_display_mux.sv
// Multiplexed common-anode 7-segment driver with frame capture, leading-zero blanking, blink and PWM.
// Define S7_HEX_EN to show 10..15 as A b C d E F; otherwise they show a dash.
module s7_display_mux #(
    parameter int DIS_NUM      = 4,
    parameter int MLT_CNT      = 10,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    s7_display_mux_if.slave bus
);
    localparam int SLOT_W = (MLT_CNT > 1) ? $clog2(MLT_CNT) : 1;
    localparam int DIG_W  = (DIS_NUM > 1) ? $clog2(DIS_NUM) : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SLOT_W-1:0]    slot_reg;
    logic [DIG_W-1:0]     digit_reg;
    logic [BRIGHT_W-1:0]  pwm_reg;
    logic [FRM_W-1:0]     frame_cnt_reg;
    logic                 blink_on_reg;
    logic [DIS_NUM*4-1:0] bcd_sh_reg;
    logic [DIS_NUM-1:0]   dp_sh_reg;
    logic                 lz_sh_reg;
    logic [DIS_NUM-1:0]   blink_sh_reg;
    logic [6:0]           seg_reg;
    logic                 dp_out_reg;
    logic [DIS_NUM-1:0]   sel_reg;
    logic                 frame_start_reg;

    logic                 slot_last, digit_last, capture;
    logic [DIS_NUM*4-1:0] bcd_eff;
    logic [DIS_NUM-1:0]   dp_eff, blink_eff;
    logic                 lz_eff;
    logic [3:0]           digit_val [DIS_NUM];
    logic [DIS_NUM-1:0]   digit_zero;
    logic [DIS_NUM-1:0]   blank_mask;
    logic                 higher_zero;
    logic                 blink_off, pwm_on;
    logic [6:0]           seg_next;
    logic                 dp_next;
    logic [DIS_NUM-1:0]   sel_next;

    assign slot_last  = (slot_reg == SLOT_W'(MLT_CNT - 1));
    assign digit_last = (digit_reg == DIG_W'(DIS_NUM - 1));
    assign capture    = (slot_reg == '0) && (digit_reg == '0);

    // On the capture edge the live inputs bypass the shadows so digit 0 shows new data at once.
    assign bcd_eff   = capture ? bus.i_bcd_data : bcd_sh_reg;
    assign dp_eff    = capture ? bus.i_dp       : dp_sh_reg;
    assign blink_eff = capture ? bus.i_blink    : blink_sh_reg;
    assign lz_eff    = capture ? bus.i_blank_lz : lz_sh_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DIS_NUM; gi++) begin : g_digit
            assign digit_val[gi]  = bcd_eff[gi*4 +: 4];
            assign digit_zero[gi] = (bcd_eff[gi*4 +: 4] == 4'd0);
        end
    endgenerate

    always_comb begin
        higher_zero = 1'b1;
        blank_mask  = '0;
        for (int k = DIS_NUM - 1; k >= 1; k--) begin
            higher_zero   = higher_zero & digit_zero[k];
            blank_mask[k] = lz_eff & higher_zero;
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'd0:    glyph = 7'b0000001;
            4'd1:    glyph = 7'b1001111;
            4'd2:    glyph = 7'b0010010;
            4'd3:    glyph = 7'b0000110;
            4'd4:    glyph = 7'b1001100;
            4'd5:    glyph = 7'b0100100;
            4'd6:    glyph = 7'b0100000;
            4'd7:    glyph = 7'b0001111;
            4'd8:    glyph = 7'b0000000;
            4'd9:    glyph = 7'b0000100;
`ifdef S7_HEX_EN
            4'd10:   glyph = 7'b0001000;
            4'd11:   glyph = 7'b1100000;
            4'd12:   glyph = 7'b0110001;
            4'd13:   glyph = 7'b1000010;
            4'd14:   glyph = 7'b0110000;
            default: glyph = 7'b0111000;
`else
            default: glyph = 7'b1111110;
`endif
        endcase
    endfunction

    always_comb begin
        blink_off = ~blink_on_reg & blink_eff[digit_reg];
        pwm_on    = (pwm_reg < bus.i_bright) || (&bus.i_bright);
        seg_next  = (blank_mask[digit_reg] || blink_off) ? 7'b1111111 : glyph(digit_val[digit_reg]);
        dp_next   = blink_off ? 1'b1 : ~dp_eff[digit_reg];
        sel_next  = pwm_on ? ~(DIS_NUM'(1) << digit_reg) : '1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            slot_reg        <= '0;
            digit_reg       <= '0;
            pwm_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_on_reg    <= 1'b1;
            bcd_sh_reg      <= '0;
            dp_sh_reg       <= '0;
            lz_sh_reg       <= 1'b0;
            blink_sh_reg    <= '0;
            seg_reg         <= 7'b1111111;
            dp_out_reg      <= 1'b1;
            sel_reg         <= '1;
            frame_start_reg <= 1'b0;
        end else begin
            pwm_reg <= pwm_reg + 1'b1;
            if (slot_last) begin
                slot_reg <= '0;
                if (digit_last) begin
                    digit_reg <= '0;
                    // Blink phase flips at the frame boundary so a frame never shows both phases.
                    if (frame_cnt_reg == FRM_W'(BLINK_FRAMES - 1)) begin
                        frame_cnt_reg <= '0;
                        blink_on_reg  <= ~blink_on_reg;
                    end else begin
                        frame_cnt_reg <= frame_cnt_reg + 1'b1;
                    end
                end else begin
                    digit_reg <= digit_reg + 1'b1;
                end
            end else begin
                slot_reg <= slot_reg + 1'b1;
            end
            if (capture) begin
                bcd_sh_reg   <= bus.i_bcd_data;
                dp_sh_reg    <= bus.i_dp;
                lz_sh_reg    <= bus.i_blank_lz;
                blink_sh_reg <= bus.i_blink;
            end
            seg_reg         <= seg_next;
            dp_out_reg      <= dp_next;
            sel_reg         <= sel_next;
            frame_start_reg <= capture;
        end
    end

    assign bus.o_segments     = seg_reg;
    assign bus.o_dp           = dp_out_reg;
    assign bus.o_segments_sel = sel_reg;
    assign bus.o_frame_start  = frame_start_reg;
endmodule

// File: tb/tb_s7_display_mux.sv
// Randomised scoreboard bench for s7_display_mux: a cycle-count reference model queues the expected pins.
module tb_s7_display_mux;
    localparam int DN    = 4;
    localparam int MC    = 10;
    localparam int BW    = 4;
    localparam int BF    = 8;
    localparam int FRAME = DN * MC;

    logic clk = 1'b0;
    logic rst = 1'b1;

    s7_display_mux_if #(.DIS_NUM(DN), .BRIGHT_W(BW)) bus ();

    s7_display_mux #(
        .DIS_NUM(DN), .MLT_CNT(MC), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]    seg;
        logic          dp;
        logic [DN-1:0] sel;
        logic          fs;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [6:0] ref_glyph(input int v);
        case (v)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
`ifdef S7_HEX_EN
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
`else
            default: return 7'b1111110;
`endif
        endcase
    endfunction

    // Reference model: everything derives from n, the number of clock edges since reset release.
    int            n;
    logic [DN*4-1:0] cap_bcd;
    logic [DN-1:0] cap_dp, cap_blink;
    logic          cap_lz;
    always @(posedge clk or posedge rst) begin : model
        int   dig, frame, pwm, val;
        logic blanked, off;
        exp_t e;
        if (rst) begin
            n = 0;
            exp_q.delete();
        end else begin
            dig   = (n / MC) % DN;
            frame = n / FRAME;
            pwm   = n % (1 << BW);
            if (n % FRAME == 0) begin
                cap_bcd   = bus.i_bcd_data;
                cap_dp    = bus.i_dp;
                cap_lz    = bus.i_blank_lz;
                cap_blink = bus.i_blink;
            end
            val     = int'((cap_bcd >> (4 * dig)) & 16'hF);
            blanked = cap_lz && dig > 0 && ((cap_bcd >> (4 * dig)) == 0);
            off     = ((frame / BF) % 2 == 1) && cap_blink[dig];
            e.seg   = (blanked || off) ? 7'b1111111 : ref_glyph(val);
            e.dp    = off ? 1'b1 : ~cap_dp[dig];
            e.sel   = (pwm < int'(bus.i_bright) || bus.i_bright == '1) ? ~(DN'(1) << dig) : '1;
            e.fs    = (n % FRAME == 0);
            exp_q.push_back(e);
            n++;
        end
    end

    task automatic check_reset(input string name);
        tests++;
        if (bus.o_segments !== 7'b1111111 || bus.o_dp !== 1'b1 ||
            bus.o_segments_sel !== '1 || bus.o_frame_start !== 1'b0) begin
            fails++;
            $display("FAIL %s: got seg=%b dp=%b sel=%b fs=%b, expected seg=1111111 dp=1 sel=1111 fs=0",
                     name, bus.o_segments, bus.o_dp, bus.o_segments_sel, bus.o_frame_start);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e, act;
        if (rst) begin
            check_reset("reset_hold");
        end else if (exp_q.size() > 0) begin
            e       = exp_q.pop_front();
            act.seg = bus.o_segments;
            act.dp  = bus.o_dp;
            act.sel = bus.o_segments_sel;
            act.fs  = bus.o_frame_start;
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL scan @%0t: got seg=%b dp=%b sel=%b fs=%b, expected seg=%b dp=%b sel=%b fs=%b",
                         $time, act.seg, act.dp, act.sel, act.fs, e.seg, e.dp, e.sel, e.fs);
            end
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic set_in(input logic [15:0] bcd, input logic [3:0] dp, input logic lz,
                          input logic [3:0] blink, input logic [3:0] bright);
        bus.i_bcd_data = bcd;
        bus.i_dp       = dp;
        bus.i_blank_lz = lz;
        bus.i_blink    = blink;
        bus.i_bright   = bright;
        $display("[TB] drive bcd=%h dp=%b lz=%b blink=%b bright=%0d", bcd, dp, lz, blink, bright);
    endtask

    task automatic mid_frame_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check_reset(name);
        cycles(3);
        rst = 1'b0;
        $display("[TB] %s released", name);
    endtask

    initial begin
        set_in(16'h1234, 4'b0000, 1'b0, 4'b0000, 4'hF);
        cycles(3);
        rst = 1'b0;
        cycles(2 * FRAME);

        set_in(16'h0050, 4'b0110, 1'b1, 4'b0000, 4'hF);
        cycles(2 * FRAME);

        set_in(16'h1111, 4'b0000, 1'b0, 4'b0000, 4'hF);
        cycles(FRAME + 15);
        set_in(16'h2222, 4'b0000, 1'b0, 4'b0000, 4'hF);
        cycles(FRAME + 30);

        set_in(16'h1234, 4'b0101, 1'b0, 4'b0001, 4'hF);
        cycles(34 * FRAME);

        set_in(16'h5678, 4'b0000, 1'b0, 4'b0000, 4'd4);
        cycles(2 * FRAME);
        set_in(16'h5678, 4'b0000, 1'b0, 4'b0000, 4'd0);
        cycles(FRAME);

        set_in(16'h00FA, 4'b0001, 1'b1, 4'b0000, 4'hF);
        cycles(2 * FRAME);
        set_in(16'h000A, 4'b0000, 1'b1, 4'b0000, 4'hF);
        cycles(FRAME + 13);
        mid_frame_reset("async_reset");
        cycles(2 * FRAME);

        for (int i = 0; i < 150; i++) begin
            set_in(16'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            if (i % 50 == 25) mid_frame_reset("random_reset");
            cycles($urandom_range(1, 70));
        end
        cycles(2);

        tests++;
        if (tests < 3000) begin
            fails++;
            $display("FAIL monitor_activity: got %0d comparisons, required at least 3000", tests);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
